// File: rtl/branch_resolve_pc_if.sv
// rtl/branch_resolve_pc_if.sv - EX-stage branch resolution bundle between the pipeline and branch_resolve_pc
//
// Purpose : groups the EX-stage request side (instruction class, comparator
//           results, computed target, stall) with the resolver's PC, redirect,
//           trap and counter outputs.
// Ports   : master - the pipeline/bench side: drives EX inputs, observes results
//           slave  - branch_resolve_pc: consumes EX inputs, drives results
interface branch_resolve_pc_if;
  logic        stall;
  logic        ex_valid;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic        br_eq;
  logic        br_lt;
  logic [31:0] target;
  logic        br_un;
  logic [31:0] pc;
  logic        taken;
  logic        flush;
  logic        trap;
  logic [31:0] badaddr;
  logic        illegal;
  logic [31:0] br_count;
  logic [31:0] taken_count;

  modport master (
    output stall, ex_valid, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt, target,
    input  br_un, pc, taken, flush, trap, badaddr, illegal, br_count, taken_count
  );

  modport slave (
    input  stall, ex_valid, is_branch, is_jal, is_jalr, funct3, br_eq, br_lt, target,
    output br_un, pc, taken, flush, trap, badaddr, illegal, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_pc.sv
// rtl/branch_resolve_pc.sv - RV32I branch/jump resolver and fetch PC owner at EX
//
// Purpose : resolves conditional branches, JAL and JALR from the comparator's
//           br_eq/br_lt, owns the fetch PC, raises redirect/flush, traps on a
//           misaligned target, flags invalid branch funct3 and counts branches.
// Ports   : clk          - system clock, rising edge
//           rst_n        - asynchronous active-low reset
//           bus (slave)  - stall, ex_valid, is_branch, is_jal, is_jalr, funct3,
//                          br_eq, br_lt, target in; br_un, pc, taken, flush,
//                          trap, badaddr, illegal, br_count, taken_count out
module branch_resolve_pc #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  branch_resolve_pc_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [31:0] pc_q;
  logic [31:0] badaddr_q;
  logic [31:0] br_count_q;
  logic [31:0] taken_count_q;
  logic        flush_q;
  logic        trap_q;
  logic        illegal_q;
  logic [2:0]  fcnt;

  logic        v;
  logic        cond;
  logic        f3_ok;
  logic        sel_jal;
  logic        sel_jalr;
  logic        sel_br;
  logic        taken_c;
  logic        mis;
  logic [31:0] tgt;
  logic [2:0]  fcnt_nxt;

  // Instructions landing in EX while the flush window is open are the
  // squashed wrong-path ones; they must not resolve.
  assign v = bus.ex_valid & (fcnt == 3'd0);

  // Decoder errors (several class bits high) resolve as jal > jalr > branch.
  assign sel_jal  = bus.is_jal;
  assign sel_jalr = bus.is_jalr & ~bus.is_jal;
  assign sel_br   = bus.is_branch & ~bus.is_jal & ~bus.is_jalr;

  always_comb begin
    cond  = 1'b0;
    f3_ok = 1'b1;
    case (bus.funct3)
      3'b000:         cond = bus.br_eq;
      3'b001:         cond = ~bus.br_eq;
      3'b100, 3'b110: cond = bus.br_lt;
      3'b101, 3'b111: cond = ~bus.br_lt;
      default:        f3_ok = 1'b0;
    endcase
  end

  assign taken_c = v & (sel_jal | sel_jalr | (sel_br & cond));
  assign tgt     = sel_jalr ? {bus.target[31:1], 1'b0} : bus.target;
  assign mis     = taken_c & (tgt[1:0] != 2'b00);

  assign fcnt_nxt = taken_c ? FLUSH_LOAD :
                    (fcnt != 3'd0) ? (fcnt - 3'd1) : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      badaddr_q     <= 32'd0;
      br_count_q    <= 32'd0;
      taken_count_q <= 32'd0;
      flush_q       <= 1'b0;
      trap_q        <= 1'b0;
      illegal_q     <= 1'b0;
      fcnt          <= 3'd0;
    end else if (!bus.stall) begin
      if (mis)          pc_q <= TRAP_VEC;
      else if (taken_c) pc_q <= tgt;
      else              pc_q <= pc_q + 32'd4;

      trap_q <= mis;
      if (mis) badaddr_q <= tgt;

      illegal_q <= v & sel_br & ~f3_ok;
      fcnt      <= fcnt_nxt;
      flush_q   <= (fcnt_nxt != 3'd0);

      if (v & sel_br & f3_ok) begin
        br_count_q <= br_count_q + 32'd1;
        if (cond) taken_count_q <= taken_count_q + 32'd1;
      end
    end
  end

  // The comparator needs its signedness select even before decode settles.
  assign bus.br_un       = bus.funct3[1];
  assign bus.taken       = taken_c;
  assign bus.pc          = pc_q;
  assign bus.flush       = flush_q;
  assign bus.trap        = trap_q;
  assign bus.badaddr     = badaddr_q;
  assign bus.illegal     = illegal_q;
  assign bus.br_count    = br_count_q;
  assign bus.taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_pc.sv
// tb/tb_branch_resolve_pc.sv - self-checking bench for branch_resolve_pc
module tb_branch_resolve_pc;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;

  logic clk;
  logic rst_n;
  branch_resolve_pc_if bus ();

  branch_resolve_pc #(
    .RESET_PC     (RESET_PC),
    .TRAP_VEC     (TRAP_VEC),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  longint      m_pc;
  longint      m_bad;
  longint      m_brc;
  longint      m_tkc;
  int          m_flush_left;
  bit          m_flush;
  bit          m_trap;
  bit          m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_bad = 0; m_brc = 0; m_tkc = 0;
    m_flush_left = 0; m_flush = 0; m_trap = 0; m_ill = 0;
  endtask

  // Branch outcome table from the ISA: returns -1 for an invalid funct3.
  function automatic int branch_outcome(input logic [2:0] f3, input bit eq, input bit lt);
    case (f3)
      3'd0: return eq ? 1 : 0;
      3'd1: return eq ? 0 : 1;
      3'd4, 3'd6: return lt ? 1 : 0;
      3'd5, 3'd7: return lt ? 0 : 1;
      default: return -1;
    endcase
  endfunction

  // Expected redirect for the inputs currently on the bus.
  bit      e_taken;
  bit      e_mis;
  longint  e_tgt;
  int      e_out;
  bit      e_valid;
  bit      e_isbr;

  task automatic predict();
    e_valid = bus.ex_valid && (m_flush_left == 0);
    e_isbr  = bus.is_branch && !bus.is_jal && !bus.is_jalr;
    e_out   = branch_outcome(bus.funct3, bus.br_eq, bus.br_lt);
    e_tgt   = bus.target;
    if (bus.is_jalr && !bus.is_jal) e_tgt = (e_tgt / 2) * 2;
    e_taken = e_valid && (bus.is_jal || bus.is_jalr || (e_isbr && e_out == 1));
    e_mis   = e_taken && (e_tgt % 4 != 0);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"}, bus.pc, 32'(m_pc));
    chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, m_flush});
    chk({tag, ".trap"}, {31'd0, bus.trap}, {31'd0, m_trap});
    chk({tag, ".badaddr"}, bus.badaddr, 32'(m_bad));
    chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, m_ill});
    chk({tag, ".br_count"}, bus.br_count, 32'(m_brc));
    chk({tag, ".taken_count"}, bus.taken_count, 32'(m_tkc));
  endtask

  task automatic step(input string tag, input bit st, input bit ev, input bit br,
                      input bit jal, input bit jalr, input logic [2:0] f3,
                      input bit eq, input bit lt, input logic [31:0] tg);
    bus.stall = st; bus.ex_valid = ev; bus.is_branch = br; bus.is_jal = jal;
    bus.is_jalr = jalr; bus.funct3 = f3; bus.br_eq = eq; bus.br_lt = lt; bus.target = tg;
    #1;
    predict();
    chk({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, e_taken});
    chk({tag, ".br_un"}, {31'd0, bus.br_un}, {31'd0, f3[1]});
    @(posedge clk);
    if (!st) begin
      m_pc   = e_mis ? TRAP_VEC : e_taken ? e_tgt : (m_pc + 4) % 64'h1_0000_0000;
      m_trap = e_mis;
      if (e_mis) m_bad = e_tgt;
      m_ill  = e_valid && e_isbr && e_out < 0;
      if (e_taken) m_flush_left = FLUSH_CYCLES;
      else if (m_flush_left > 0) m_flush_left--;
      m_flush = (m_flush_left != 0);
      if (e_valid && e_isbr && e_out >= 0) begin
        m_brc = (m_brc + 1) % 64'h1_0000_0000;
        if (e_out == 1) m_tkc = (m_tkc + 1) % 64'h1_0000_0000;
      end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 3'd0, 0, 0, 32'd0);
  endtask

  initial begin
    bus.stall = 0; bus.ex_valid = 0; bus.is_branch = 0; bus.is_jal = 0;
    bus.is_jalr = 0; bus.funct3 = 0; bus.br_eq = 0; bus.br_lt = 0; bus.target = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    rst_n = 1;

    // Sequential fetch.
    idle("seq1"); idle("seq2");
    chk("seq.pc8", bus.pc, 32'h8);
    idle("seq3");
    chk("seq.pcC", bus.pc, 32'hC);

    // Restart from a known point: redirect at pc=0x8 is reached after reset.
    rst_n = 0; #1; model_reset(); check_regs("rst2"); #2; rst_n = 1;
    idle("pre1"); idle("pre2");
    step("beq", 0, 1, 1, 0, 0, 3'b000, 1, 0, 32'h40);
    chk("beq.pc40", bus.pc, 32'h40);
    chk("beq.tkc", bus.taken_count, 32'd1);
    step("beq_in_flush", 0, 1, 1, 0, 0, 3'b000, 1, 0, 32'h80);
    idle("flush_end");
    chk("flush_end.flush", {31'd0, bus.flush}, 32'd0);

    // bgeu not taken, then invalid funct3.
    step("bgeu", 0, 1, 1, 0, 0, 3'b111, 0, 1, 32'h200);
    step("f3_011", 0, 1, 1, 0, 0, 3'b011, 1, 1, 32'h200);
    chk("f3_011.illegal", {31'd0, bus.illegal}, 32'd1);
    idle("ill_clear");

    // JALR misaligned, then JALR whose low bit is dropped.
    step("jalr_mis", 0, 1, 0, 0, 1, 3'b000, 0, 0, 32'h0000_0123);
    chk("jalr_mis.badaddr", bus.badaddr, 32'h122);
    chk("jalr_mis.pc", bus.pc, 32'h100);
    idle("jm1"); idle("jm2");
    step("jalr_ok", 0, 1, 0, 0, 1, 3'b000, 0, 0, 32'h0000_0201);
    chk("jalr_ok.pc", bus.pc, 32'h200);
    idle("jo1"); idle("jo2");

    // Taken JAL held under stall, then a stall inside the flush window.
    repeat (3) step("jal_stall", 1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h80);
    step("jal_go", 0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h80);
    chk("jal_go.pc", bus.pc, 32'h80);
    step("fl_stall", 1, 0, 0, 0, 0, 3'b000, 0, 0, 32'd0);
    idle("fl1"); idle("fl2");

    // Wrap and async reset during flush.
    step("jal_top", 0, 1, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFFC);
    idle("wrap");
    chk("wrap.pc", bus.pc, 32'h0);
    #2; rst_n = 0; #1; model_reset();
    chk("async.flush", {31'd0, bus.flush}, 32'd0);
    check_regs("async");
    #2; rst_n = 1;
    idle("post_rst");
    chk("post_rst.pc", bus.pc, RESET_PC + 32'd4);

    // Randomized traffic against the model (one-hot or no class bit).
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [31:0] tg;
      k  = $urandom_range(0, 3);
      tg = $urandom;
      if ($urandom_range(0, 1) == 0) tg[1:0] = 2'b00;
      step("rand", $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6,
           k == 1, k == 2, k == 3, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_pc.md
Name: branch_resolve_pc

Overview:
- Consumes the branch comparator's br_eq/br_lt, resolves RV32I conditional branches and JAL/JALR, and owns the fetch PC register.
- Drives br_un back to the comparator.
- Issues redirect, pipeline flush, misaligned-target trap and illegal-funct3 indications.
- Keeps branch performance counters.
- Sits at the EX stage, beside the branch comparator, feeding IF.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned redirect target.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect or trap (range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze all state this cycle.
- ex_valid  in  1  an instruction occupies EX.
- is_branch  in  1  EX instruction is a conditional branch.
- is_jal  in  1  EX instruction is JAL.
- is_jalr  in  1  EX instruction is JALR.
- funct3  in  3  branch funct3 of EX instruction.
- br_eq  in  1  comparator equal result.
- br_lt  in  1  comparator less-than result.
- target  in  32  ALU-computed target address.
- br_un  out  1  unsigned-compare select to comparator.
- pc  out  32  current fetch PC (registered).
- taken  out  1  redirect decision this cycle (combinational).
- flush  out  1  squash IF/ID contents (registered).
- trap  out  1  one-cycle misaligned-target pulse (registered).
- badaddr  out  32  offending target, latched on trap.
- illegal  out  1  one-cycle invalid-funct3 pulse (registered).
- br_count  out  32  resolved conditional branches.
- taken_count  out  32  taken conditional branches.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC
  - flush=0, trap=0, illegal=0
  - badaddr=0, br_count=0, taken_count=0
  - internal flush counter fcnt=0
- br_un = funct3[1], purely combinational, not gated by is_branch.
- Effective valid: v = ex_valid & (fcnt==0). Instructions reaching EX during a flush window are ignored.
- Branch condition cond, by funct3:
  - 000 → br_eq
  - 001 → ~br_eq
  - 100 → br_lt
  - 101 → ~br_lt
  - 110 → br_lt
  - 111 → ~br_lt
  - 010 / 011 → 0, invalid.
- Combinational decision: taken = v & (is_jal | is_jalr | (is_branch & cond)).
- Effective target: tgt = is_jalr ? {target[31:1],1'b0} : target.
- Misalignment: mis = taken & (tgt[1:0] != 0).
- When stall=1, every register holds, including fcnt, counters and pulses. Upstream holds EX inputs stable across the stall. Stall takes priority over redirect.
- When stall=0, on each rising edge:
  - pc: if mis then TRAP_VEC; else if taken then tgt; else pc+4 (32-bit wrap, FFFF_FFFC→0000_0000).
  - trap <= mis; badaddr <= tgt when mis, otherwise holds.
  - illegal <= v & is_branch & (funct3==010 | funct3==011).
  - fcnt: if taken (including mis) then FLUSH_CYCLES; else if fcnt!=0 then fcnt-1.
  - flush <= (next fcnt != 0). flush is high for exactly FLUSH_CYCLES unstalled cycles starting the cycle after the redirect.
  - br_count += 1 when v & is_branch & valid funct3.
  - taken_count += 1 when additionally cond=1, including a misaligned taken branch.
  - Both counters wrap modulo 2^32.
- More than one of is_branch/is_jal/is_jalr high is a decoder error: priority is jal > jalr > branch. Only a branch-qualified event updates the counters.
- Latency: redirect decision is combinational in EX. The new pc is visible one cycle later. Flush follows in the same cycle as the new pc.
- Reset asserted mid-flush or mid-stall clears everything immediately. The first post-reset edge yields pc=RESET_PC+4 unless stalled.

Test Plan:
- Reset, then 3 unstalled cycles with ex_valid=0 → pc 0x0, 0x4, 0x8, 0xC; flush=0; counters 0.
- At pc=0x8: ex_valid=1, is_branch=1, funct3=000, br_eq=1, target=0x40 → taken=1 that cycle. Next cycle pc=0x40 and flush=1 for 2 cycles. br_count=1, taken_count=1. A valid branch inside the flush window is ignored.
- funct3=111, br_lt=1, is_branch=1 → br_un=1, taken=0, pc+4, br_count increments, taken_count unchanged. Then funct3=011 → illegal pulses 1 cycle and br_count unchanged.
- JALR with target=0x0000_0123 → tgt 0x122 is misaligned: pc=TRAP_VEC 0x100, trap=1 for 1 cycle, badaddr=0x122, flush 2 cycles. JALR target=0x0000_0201 → pc=0x200, no trap.
- Taken JAL to 0x80 with stall=1 held 3 cycles → pc and counters frozen. On stall release pc=0x80, flush for 2 cycles. A stall during flush extends the window by the stalled cycles.
- Force pc to 0xFFFF_FFFC via a JAL → next unstalled cycle pc=0x0. Assert rst_n=0 asynchronously mid-flush → flush=0, pc=RESET_PC immediately.
